// File: rtl/pwm_timer_pkg.sv
// Shared constants for the PWM/timer peripheral: counter width, ctrl register
// bit positions and the mode / timer-mode encodings.
package pwm_timer_pkg;

   localparam int CNT_WIDTH = 16;

   localparam int CTRL_MODE  = 1;
   localparam int CTRL_EN    = 2;
   localparam int CTRL_TMODE = 3;

   localparam logic MODE_PWM    = 1'b1;
   localparam logic MODE_TIMER  = 1'b0;
   localparam logic TMR_CONT    = 1'b1;
   localparam logic TMR_ONESHOT = 1'b0;

endpackage

// File: rtl/main_counter_term.sv
// Terminal-count compare for the main counter: flags the terminal value for the
// current mode and supplies the wrapped/incremented next count.
module main_counter_term
   import pwm_timer_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic [WIDTH-1:0] counter,
   input  logic [WIDTH-1:0] period_reg,
   input  logic             mode,
   output logic             at_term,
   output logic [WIDTH-1:0] cnt_next
);

   always_comb begin
      at_term = 1'b0;
      if (mode == MODE_PWM) begin
         // Periods 0 and 1 pin the count at 0; the guard also avoids underflow.
         if (period_reg > WIDTH'(1)) begin
            at_term = (counter >= (period_reg - WIDTH'(1)));
         end else begin
            at_term = 1'b1;
         end
      end else begin
         at_term = (counter >= period_reg);
      end
      cnt_next = at_term ? '0 : (counter + WIDTH'(1));
   end

endmodule

// File: rtl/main_counter_core.sv
// Shared up-counter for the PWM/timer peripheral on slow_clk.
// Optional wrap pulse output enabled by defining MAIN_COUNTER_WRAP_FLAG_EN.
module main_counter_core
   import pwm_timer_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic             sw_rst,
   input  logic             counter_en,
   input  logic             mode,
   input  logic             timer_mode,
   input  logic [WIDTH-1:0] period_reg,
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
   output logic             wrap,
`endif
   output logic [WIDTH-1:0] counter
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             done_q, done_d;
   logic             at_term;
   logic [WIDTH-1:0] cnt_next;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
   logic             wrap_q, wrap_d;
`endif

   main_counter_term #(.WIDTH(WIDTH)) u_term (
      .counter    (cnt_q),
      .period_reg (period_reg),
      .mode       (mode),
      .at_term    (at_term),
      .cnt_next   (cnt_next)
   );

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      done_d  = done_q;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
      wrap_d  = 1'b0;
`endif
      if (sw_rst) begin
         cnt_d   = '0;
         armed_d = 1'b0;
         done_d  = 1'b0;
      end else if (counter_en) begin
         // Selecting continuous mode releases a finished one-shot.
         if (timer_mode == TMR_CONT) begin
            done_d = 1'b0;
         end
         if (mode == MODE_PWM) begin
            cnt_d   = cnt_next;
            armed_d = 1'b0;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
            wrap_d  = at_term;
`endif
         end else if (!armed_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
         end else if (done_q) begin
            cnt_d = '0;
         end else if (at_term) begin
            cnt_d = '0;
            if (timer_mode == TMR_ONESHOT) begin
               done_d = 1'b1;
            end
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
            wrap_d = 1'b1;
`endif
         end else begin
            cnt_d = cnt_next;
         end
      end
   end

   always_ff @(posedge slow_clk) begin
      if (rst) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
         wrap_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         done_q  <= done_d;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
         wrap_q  <= wrap_d;
`endif
      end
   end

   assign counter = cnt_q;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
   assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_main_counter_core.sv
// Bench for main_counter_core: directed sequences with literal expectations,
// then randomized control traffic checked against a behavioural model.
module tb_main_counter_core;

   localparam int W = 16;

   logic          slow_clk = 1'b0;
   logic          rst = 1'b1;
   logic          sw_rst = 1'b0;
   logic          counter_en = 1'b0;
   logic          mode = 1'b0;
   logic          timer_mode = 1'b0;
   logic [W-1:0]  period_reg = '0;
   logic [W-1:0]  counter;
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
   logic          wrap;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: plain integers stepped by the rules of the counter.
   int  m_cnt = 0;
   bit  m_armed = 0;
   bit  m_done = 0;

   logic [W-1:0] exp_q[$];

   main_counter_core dut (
      .slow_clk   (slow_clk),
      .rst        (rst),
      .sw_rst     (sw_rst),
      .counter_en (counter_en),
      .mode       (mode),
      .timer_mode (timer_mode),
      .period_reg (period_reg),
`ifdef MAIN_COUNTER_WRAP_FLAG_EN
      .wrap       (wrap),
`endif
      .counter    (counter)
   );

   // clock / reset block
   always #5 slow_clk = ~slow_clk;

   function automatic void model_edge();
      int p;
      int limit;
      p = int'(period_reg);
      if (rst || sw_rst) begin
         m_cnt = 0; m_armed = 0; m_done = 0;
      end else if (counter_en) begin
         if (mode) begin
            limit = (p > 1) ? p - 1 : 0;
            m_cnt = (m_cnt >= limit) ? 0 : m_cnt + 1;
            m_armed = 0;
         end else if (!m_armed) begin
            m_cnt = 0; m_armed = 1;
         end else if (m_done) begin
            m_cnt = 0;
         end else if (m_cnt >= p) begin
            m_cnt = 0;
            if (!timer_mode) m_done = 1;
         end else begin
            m_cnt = m_cnt + 1;
         end
         if (timer_mode) m_done = 0;
      end
   endfunction

   // driver tasks
   task automatic step();
      model_edge();
      @(posedge slow_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] exp);
      checks++;
      assert (counter === exp) else begin
         errors++;
         $error("FAIL %s: counter=%0d expected=%0d", tag, counter, exp);
      end
   endtask

   task automatic run_expect(input string tag);
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         step();
         check(tag, e);
      end
   endtask

   task automatic set_ctrl(input logic en, input logic md, input logic tm, input int p);
      counter_en = en;
      mode       = md;
      timer_mode = tm;
      period_reg = W'(p);
   endtask

   initial begin
      // reset out of power-up
      set_ctrl(1'b0, 1'b1, 1'b0, 4);
      rst = 1'b1;
      step();
      check("reset_initial", '0);
      rst = 1'b0;

      // PWM period 4
      set_ctrl(1'b1, 1'b1, 1'b0, 4);
      exp_q = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
      run_expect("pwm_p4");

      // reset from a non-zero count, then held with enable on
      rst = 1'b1;
      step();
      check("reset_from_count", '0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_held", '0);
      end
      rst = 1'b0;

      // timer continuous, period 4
      set_ctrl(1'b1, 1'b0, 1'b1, 4);
      exp_q = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
      run_expect("tmr_cont_p4");

      // timer one-shot, period 4, after a software reset
      sw_rst = 1'b1;
      set_ctrl(1'b1, 1'b0, 1'b0, 4);
      step();
      check("sw_rst_clear", '0);
      sw_rst = 1'b0;
      exp_q = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
      run_expect("tmr_oneshot_p4");

      // software reset re-runs the one-shot
      sw_rst = 1'b1;
      step();
      check("sw_rst_rerun", '0);
      sw_rst = 1'b0;
      exp_q = '{0, 1, 2, 3, 4, 0, 0};
      run_expect("tmr_oneshot_rerun");

      // one-shot with period 0: arm, then parked at 0
      sw_rst = 1'b1;
      set_ctrl(1'b1, 1'b0, 1'b0, 0);
      step();
      sw_rst = 1'b0;
      exp_q = '{0, 0, 0, 0};
      run_expect("tmr_oneshot_p0");

      // switching to continuous releases the finished one-shot
      set_ctrl(1'b1, 1'b0, 1'b1, 3);
      exp_q = '{0, 1, 2, 3, 0};
      run_expect("tmr_release_cont");

      // PWM period 1 stays at 0
      set_ctrl(1'b1, 1'b1, 1'b0, 1);
      exp_q = '{0, 0, 0};
      run_expect("pwm_p1");

      // mid-count reset in PWM period 10
      rst = 1'b1; step(); rst = 1'b0;
      set_ctrl(1'b1, 1'b1, 1'b0, 10);
      exp_q = '{1, 2, 3, 4, 5};
      run_expect("pwm_p10_up");
      sw_rst = 1'b1;
      step();
      check("pwm_mid_sw_rst", '0);
      sw_rst = 1'b0;

      // disable mid-count, hold, then resume
      exp_q = '{1, 2, 3, 4, 5};
      run_expect("pwm_p10_up2");
      counter_en = 1'b0;
      exp_q = '{5, 5, 5, 5, 5};
      run_expect("pwm_disabled_hold");
      counter_en = 1'b1;
      exp_q = '{6, 7, 8, 9, 0, 1};
      run_expect("pwm_resume");

      // period shrinks below the current count: wrap on next edge
      exp_q = '{2, 3, 4, 5, 6};
      run_expect("pwm_p10_up3");
      period_reg = W'(4);
      exp_q = '{0, 1};
      run_expect("pwm_period_shrink");

      // randomized control traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         sw_rst     = ($urandom_range(0, 39) == 0);
         counter_en = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 24) == 0) mode = ~mode;
         if ($urandom_range(0, 14) == 0) timer_mode = ~timer_mode;
         if ($urandom_range(0, 19) == 0) period_reg = W'($urandom_range(0, 12));
         step();
         check("random_vs_model", W'(m_cnt));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
